// File: rtl/raster_pkg.sv
// Shared constants for the rectangle-fill raster path.
// Holds the FSM state encoding, the default coordinate widths and the screen size.
package raster_pkg;

    localparam int DEF_X_W      = 8;
    localparam int DEF_Y_W      = 7;
    localparam int DEF_COLOR_W  = 3;
    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LATCH  = 2'd1,
        DRAW   = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/raster_fill_ctrl_if.sv
// Command and pixel-beat bundle between a fill requester and raster_fill_ctrl.
// The requester drives the command and hold; the controller drives the beat stream.
interface raster_fill_ctrl_if #(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COLOR_W = 3
);
    logic               start;
    logic [X_W-1:0]     x0;
    logic [Y_W-1:0]     y0;
    logic [X_W-1:0]     w;
    logic [Y_W-1:0]     h;
    logic [COLOR_W-1:0] color_in;
    logic               hold;

    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COLOR_W-1:0] colour;
    logic               plot;
    logic               busy;
    logic               done;

    modport master (
        output start, x0, y0, w, h, color_in, hold,
        input  x, y, colour, plot, busy, done
    );

    modport slave (
        input  start, x0, y0, w, h, color_in, hold,
        output x, y, colour, plot, busy, done
    );

endinterface

// File: rtl/xy_scan_counter.sv
// Nested column/row offset counter: cx runs 0..w-1, then wraps and steps cy 0..h-1.
// last flags the final (w-1, h-1) position so the caller can stop after that beat.
module xy_scan_counter #(
    parameter int X_W = 8,
    parameter int Y_W = 7
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           clear,
    input  logic           enable,
    input  logic [X_W-1:0] w,
    input  logic [Y_W-1:0] h,
    output logic [X_W-1:0] cx,
    output logic [Y_W-1:0] cy,
    output logic           last
);

    logic [X_W-1:0] cx_reg, cx_next;
    logic [Y_W-1:0] cy_reg, cy_next;
    logic           row_end;
    logic           col_end;

    assign row_end = (cx_reg == w - X_W'(1));
    assign col_end = (cy_reg == h - Y_W'(1));

    always_comb begin
        cx_next = cx_reg;
        cy_next = cy_reg;
        if (clear) begin
            cx_next = '0;
            cy_next = '0;
        end else if (enable) begin
            if (row_end) begin
                cx_next = '0;
                // Wrapping cy on the final beat leaves the counter ready for the next command.
                cy_next = col_end ? '0 : cy_reg + Y_W'(1);
            end else begin
                cx_next = cx_reg + X_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cx_reg <= '0;
            cy_reg <= '0;
        end else begin
            cx_reg <= cx_next;
            cy_reg <= cy_next;
        end
    end

    assign cx   = cx_reg;
    assign cy   = cy_reg;
    assign last = row_end && col_end;

endmodule

// File: rtl/raster_fill_ctrl.sv
// Rectangle-fill raster generator: latches a fill command, then emits one clipped
// (x, y, colour, plot) beat per unpaused cycle and pulses done after the last one.
module raster_fill_ctrl
    import raster_pkg::*;
#(
    parameter int X_W      = DEF_X_W,
    parameter int Y_W      = DEF_Y_W,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int COLOR_W  = DEF_COLOR_W
) (
    input  logic               clk,
    input  logic               resetn,
    raster_fill_ctrl_if.slave  bus
);

    state_t state_reg, state_next;

    logic [X_W-1:0]     x0_reg;
    logic [Y_W-1:0]     y0_reg;
    logic [X_W-1:0]     w_reg;
    logic [Y_W-1:0]     h_reg;
    logic [COLOR_W-1:0] colour_reg;
    logic [X_W-1:0]     x_reg;
    logic [Y_W-1:0]     y_reg;

    logic [X_W-1:0] cx;
    logic [Y_W-1:0] cy;
    logic           last;

    logic           accept;
    logic           step;
    logic           empty;
    logic [X_W:0]   sum_x;
    logic [Y_W:0]   sum_y;
    logic           clipped;

    assign accept = (state_reg == IDLE) && bus.start;
    assign step   = (state_reg == DRAW) && !bus.hold;
    assign empty  = (w_reg == '0) || (h_reg == '0);

    // One extra bit so an origin near the top of the range cannot wrap back on-screen.
    assign sum_x   = {1'b0, x0_reg} + {1'b0, cx};
    assign sum_y   = {1'b0, y0_reg} + {1'b0, cy};
    assign clipped = (sum_x >= (X_W+1)'(SCREEN_W)) || (sum_y >= (Y_W+1)'(SCREEN_H));

    xy_scan_counter #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_scan (
        .clk    (clk),
        .resetn (resetn),
        .clear  (accept),
        .enable (step),
        .w      (w_reg),
        .h      (h_reg),
        .cx     (cx),
        .cy     (cy),
        .last   (last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:   if (bus.start) state_next = LATCH;
            LATCH:  state_next = empty ? FINISH : DRAW;
            DRAW:   if (step && last) state_next = FINISH;
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy   = (state_reg == LATCH) || (state_reg == DRAW);
        bus.done   = (state_reg == FINISH);
        bus.plot   = step && !clipped;
        bus.colour = colour_reg;
        // Outside a live beat the outputs show the most recent beat, so hold freezes them.
        bus.x      = step ? sum_x[X_W-1:0] : x_reg;
        bus.y      = step ? sum_y[Y_W-1:0] : y_reg;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x0_reg     <= '0;
            y0_reg     <= '0;
            w_reg      <= '0;
            h_reg      <= '0;
            colour_reg <= '0;
            x_reg      <= '0;
            y_reg      <= '0;
        end else begin
            if (accept) begin
                x0_reg     <= bus.x0;
                y0_reg     <= bus.y0;
                w_reg      <= bus.w;
                h_reg      <= bus.h;
                colour_reg <= bus.color_in;
            end
            if (step) begin
                x_reg <= sum_x[X_W-1:0];
                y_reg <= sum_y[Y_W-1:0];
            end
        end
    end

endmodule

// File: doc/raster_fill_ctrl.md
Name: raster_fill_ctrl

Overview:
Parametrised rectangle-fill raster generator for the VGA adapter path. It accepts a start command with origin, size and colour, then sweeps a nested column/row counter and emits one (x, y, colour, plot) beat per cycle. Beats are clipped to the screen bounds, a hold input can pause the sweep, and completion is reported with busy/done. The sweep replaces the free-running scan counters and serves both full-screen background clears and sprite/box draws.

Parameters:
X_W, 8, width of x coordinate and width fields
Y_W, 7, width of y coordinate and height fields
SCREEN_W, 160, visible columns; x >= SCREEN_W is clipped
SCREEN_H, 120, visible rows; y >= SCREEN_H is clipped
COLOR_W, 3, colour width

Ports:
clk  in  1  system clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  command strobe, sampled only in IDLE
x0  in  X_W  rectangle origin column
y0  in  Y_W  rectangle origin row
w  in  X_W  rectangle width in pixels; 0 = empty
h  in  Y_W  rectangle height in pixels; 0 = empty
color_in  in  COLOR_W  fill colour
hold  in  1  pause sweep; counters and outputs freeze, plot forced 0
x  out  X_W  current pixel column
y  out  Y_W  current pixel row
colour  out  COLOR_W  latched fill colour
plot  out  1  write strobe to VGA adapter
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse after the last beat

Behaviour:
- Reset (async, resetn=0): state IDLE; x, y, colour, cx, cy = 0; plot, busy, done = 0. Reset mid-sweep aborts immediately with no done pulse.
- States: IDLE, LATCH, DRAW, FINISH.
- IDLE: start=1 at edge N -> register x0, y0, w, h, color_in; clear cx, cy; go to LATCH. busy=1 from cycle N+1.
- LATCH: if w==0 or h==0, go to FINISH (no beats). Otherwise go to DRAW.
- DRAW: first beat in cycle N+2. Each cycle with hold=0: x = x0+cx, y = y0+cy, and plot=1 unless clipped. Then cx increments; at cx==w-1, cx wraps to 0 and cy increments. The beat with cx==w-1 and cy==h-1 is the last beat, after which the FSM goes to FINISH. With hold=1 the counters do not advance, plot=0, and x/y hold their values.
- Clip: sums are formed at X_W+1 and Y_W+1 bits. If x0+cx >= SCREEN_W or y0+cy >= SCREEN_H, plot=0 for that beat, but the counters still advance. The x/y outputs carry the truncated sum.
- FINISH: done=1 and busy=0 for exactly one cycle, then return to IDLE.
- Start outside IDLE is ignored. Command inputs are don't-care except at the accept edge.
- Throughput: w*h + (hold cycles) DRAW cycles. Total latency from start to the done pulse is w*h + 2 + holds.
- colour output is stable for the whole command and equals the latched value.

Decomposition:
- Shared package raster_pkg holds the state encoding localparams (IDLE=0, LATCH=1, DRAW=2, FINISH=3) and the screen defaults SCREEN_W=160 and SCREEN_H=120. The default widths X_W and Y_W are also defined there.
- One sub-module, xy_scan_counter:
  - parametrised nested cx/cy counter with enable, clear, w/h limits and a last flag;
  - instantiated once in the top.

Test Plan:
- Box draw: start with x0=10, y0=20, w=4, h=3, color_in=5 -> 12 plots, x sequence 10..13 repeated over y 20..22, colour=5 throughout. The first plot is 2 cycles after start and done is on cycle 14.
- Full clear: start with x0=0, y0=0, w=160, h=120, color_in=0 -> 19200 plots, last beat at (159,119), done once, busy low afterwards.
- Clip: start with x0=158, y0=118, w=4, h=4 -> 16 beats, of which only 4 have plot=1, at (158,118), (159,118), (158,119) and (159,119). done arrives on cycle 18.
- Empty and ignored start: w=0 -> no plot and done 2 cycles after start. Start pulsed during DRAW of a 4x3 box -> ignored, still exactly 12 plots.
- Hold: assert hold for 5 cycles after the 3rd beat of the 4x3 box -> plot=0 and x/y frozen during hold, sequence resumes at the 4th beat, done is delayed by 5 cycles.
- Reset mid-sweep: drop resetn during the 6th beat -> all outputs go to 0 asynchronously and no done pulse occurs. A new start after release draws correctly from cx=cy=0.
